// File: rtl/async_load_seq.sv
// async_load_seq: forces a value into an async-load flop bank and checks the readback
module async_load_seq #(
  parameter int WIDTH  = 8,
  parameter int HOLD   = 2,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  output logic [WIDTH-1:0] ff_rval,
  output logic             ff_arst,
  input  logic [WIDTH-1:0] ff_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_err
);
  if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
    $error("async_load_seq: HOLD must be in 1..255");
  end
  if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
    $error("async_load_seq: SETTLE must be in 1..255");
  end
  typedef enum logic [2:0] {IDLE, SETUP, ASSERT, RELEASE, RESP} state_t;
  localparam logic [7:0] HOLD_M1   = 8'(HOLD - 1);
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);
  state_t           state_q;
  logic [7:0]       cnt_q;
  logic [WIDTH-1:0] val_q;
  logic             ff_arst_q, ready_q, rsp_valid_q, rsp_err_q;
  // sequencer: every output is a flop, so ff_arst is glitch-free and drops with arst
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      val_q       <= '0;
      ff_arst_q   <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE:
          if (req_valid && ready_q) begin
            val_q   <= req_data;
            ready_q <= 1'b0;
            state_q <= SETUP;
          end else begin
            ready_q <= 1'b1;
          end
        SETUP: begin
          ff_arst_q <= 1'b1;
          cnt_q     <= HOLD_M1;
          state_q   <= ASSERT;
        end
        ASSERT:
          if (cnt_q == 8'd0) begin
            ff_arst_q <= 1'b0;
            cnt_q     <= SETTLE_M1;
            state_q   <= RELEASE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        RELEASE:
          if (cnt_q == 8'd0) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ff_q != val_q;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        RESP:
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end
        default: state_q <= IDLE;
      endcase
    end
  assign req_ready = ready_q;
  assign ff_rval   = val_q;
  assign ff_arst   = ff_arst_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_async_load_seq.sv
// tb_async_load_seq: scoreboard bench over three parameter sets with a modelled flop bank
module tb_async_load_seq;
  localparam int N = 3;
  typedef struct {
    logic       err;
    logic [7:0] val;
    int         acc;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] arst, req_valid, req_ready, ff_arst, rsp_valid, rsp_ready, rsp_err;
  logic [7:0]   req_data [N];
  logic [7:0]   ff_rval  [N];
  logic [7:0]   ff_q     [N];
  logic [7:0]   stuck = 8'h00;
  int cyc = 0, checks = 0, errors = 0;
  int hs_cyc [N];
  exp_t sb [N][$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  for (genvar g = 0; g < N; g++) begin : g_inst
    localparam int H = g == 0 ? 2 : g == 1 ? 1 : 255;
    localparam int S = g == 0 ? 1 : g == 1 ? 1 : 255;
    logic [7:0] bank_q;
    async_load_seq #(.WIDTH(8), .HOLD(H), .SETTLE(S)) dut (
      .clk(clk), .arst(arst[g]), .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_data(req_data[g]), .ff_rval(ff_rval[g]), .ff_arst(ff_arst[g]), .ff_q(ff_q[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_err(rsp_err[g])
    );
    always @(posedge clk or posedge ff_arst[g])
      if (ff_arst[g]) bank_q <= ff_rval[g];
    assign ff_q[g] = bank_q & ~(g == 0 ? stuck : 8'h00);
    initial begin : mon
      int hcnt;
      bit vprev;
      exp_t e;
      hcnt = 0;
      vprev = 0;
      forever begin
        @(negedge clk);
        if (arst[g]) begin
          hcnt = 0;
          vprev = 0;
        end else begin
          if (ff_arst[g]) hcnt++;
          else if (hcnt > 0) begin
            chk($sformatf("i%0d hold", g), hcnt, H);
            hcnt = 0;
          end
          if (rsp_valid[g]) begin
            chk($sformatf("i%0d ready_busy", g), req_ready[g], 0);
            if (sb[g].size() == 0) chk($sformatf("i%0d spurious_rsp", g), 1, 0);
            else begin
              e = sb[g][0];
              chk($sformatf("i%0d rsp_err", g), rsp_err[g], e.err);
              chk($sformatf("i%0d rval_hold", g), ff_rval[g], e.val);
              if (!vprev) chk($sformatf("i%0d latency", g), cyc - e.acc, H + S + 1);
              if (rsp_ready[g]) begin
                hs_cyc[g] = cyc + 1;
                void'(sb[g].pop_front());
              end
            end
          end
          vprev = rsp_valid[g] && !rsp_ready[g];
        end
      end
    end
  end
  task automatic load(input int i, input logic [7:0] d, input bit err, input bit push,
                      input bit keep, output int acc);
    int n;
    exp_t e;
    @(negedge clk);
    req_data[i] = d;
    req_valid[i] = 1'b1;
    n = 0;
    while (!req_ready[i] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      chk($sformatf("i%0d accept_timeout", i), 1, 0);
      req_valid[i] = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    e.err = err;
    e.val = d;
    e.acc = acc;
    if (push) sb[i].push_back(e);
    @(posedge clk);
    #1;
    if (!keep) begin
      req_valid[i] = 1'b0;
      req_data[i] = ~d;
    end
    chk($sformatf("i%0d rval_at_accept", i), ff_rval[i], d);
  endtask
  task automatic drain(input int i);
    int n;
    n = 0;
    while (sb[i].size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk($sformatf("i%0d drain_timeout", i), 1, 0);
    @(negedge clk);
  endtask
  initial begin
    int a1, a2, n;
    arst = '1;
    rsp_ready = '1;
    req_valid = '0;
    for (int i = 0; i < N; i++) req_data[i] = 8'h00;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("i%0d rst_rsp_valid", i), rsp_valid[i], 0);
      chk($sformatf("i%0d rst_rsp_err", i), rsp_err[i], 0);
      chk($sformatf("i%0d rst_ff_arst", i), ff_arst[i], 0);
      chk($sformatf("i%0d rst_ff_rval", i), ff_rval[i], 0);
    end
    arst = '0;
    @(negedge clk);
    for (int i = 0; i < N; i++) chk($sformatf("i%0d ready_after_rst", i), req_ready[i], 1);
    load(0, 8'hA5, 1'b0, 1'b1, 1'b0, a1);
    drain(0);
    chk("i0 bank_readback", ff_q[0], 8'hA5);
    stuck = 8'h08;
    load(0, 8'hFF, 1'b1, 1'b1, 1'b0, a1);
    drain(0);
    load(0, 8'hF7, 1'b0, 1'b1, 1'b0, a1);
    drain(0);
    stuck = 8'h00;
    rsp_ready[0] = 1'b0;
    load(0, 8'h11, 1'b0, 1'b1, 1'b0, a1);
    n = 0;
    while (!rsp_valid[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("i0 bp_rsp_seen", rsp_valid[0], 1);
    req_data[0] = 8'h3C;
    req_valid[0] = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    rsp_ready[0] = 1'b1;
    load(0, 8'h3C, 1'b0, 1'b1, 1'b0, a2);
    chk("i0 accept_after_hs", a2, hs_cyc[0] + 1);
    drain(0);
    load(0, 8'h77, 1'b0, 1'b0, 1'b0, a1);
    n = 0;
    while (!ff_arst[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("i0 ff_arst_before_abort", ff_arst[0], 1);
    @(posedge clk);
    #2;
    arst[0] = 1'b1;
    #1;
    chk("i0 ff_arst_async_drop", ff_arst[0], 0);
    @(negedge clk);
    #2;
    arst[0] = 1'b0;
    @(negedge clk);
    chk("i0 ready_after_abort", req_ready[0], 1);
    repeat (6) begin
      @(negedge clk);
      chk("i0 no_rsp_after_abort", rsp_valid[0], 0);
    end
    load(0, 8'h5A, 1'b0, 1'b1, 1'b0, a1);
    drain(0);
    chk("i0 bank_after_abort", ff_q[0], 8'h5A);
    load(1, 8'hC3, 1'b0, 1'b1, 1'b1, a1);
    load(1, 8'h3C, 1'b0, 1'b1, 1'b0, a2);
    chk("i1 spacing", a2 - a1, 1 + 1 + 3);
    drain(1);
    chk("i1 bank_readback", ff_q[1], 8'h3C);
    load(2, 8'h96, 1'b0, 1'b1, 1'b1, a1);
    load(2, 8'h69, 1'b0, 1'b1, 1'b0, a2);
    chk("i2 spacing", a2 - a1, 255 + 255 + 3);
    drain(2);
    chk("i2 bank_readback", ff_q[2], 8'h69);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/async_load_seq.md
ASYNC_LOAD_SEQ -- requirements
Module: async_load_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: width of the load value and flop bank.
REQ-002 The block SHALL have parameter HOLD, default 2: number of cycles ff_arst stays high; legal range 1..255.
REQ-003 The block SHALL have parameter SETTLE, default 1: number of cycles after ff_arst falls before the bank is checked; legal range 1..255.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port arst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port req_valid, input, 1 bit: load request valid.
REQ-007 The block SHALL have port req_ready, output, 1 bit: block idle, request accepted when req_valid && req_ready.
REQ-008 The block SHALL have port req_data, input, WIDTH bits: value to force into the bank.
REQ-009 The block SHALL have port ff_rval, output, WIDTH bits: drives rval of every bank flop.
REQ-010 The block SHALL have port ff_arst, output, 1 bit: drives arst of every bank flop.
REQ-011 The block SHALL have port ff_q, input, WIDTH bits: q outputs of the bank, read back for checking.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: load result valid.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: result consumed when rsp_valid && rsp_ready.
REQ-014 The block SHALL have port rsp_err, output, 1 bit: 1 = readback mismatch; qualified by rsp_valid.

Function
REQ-015 The block SHALL implement FSM states IDLE, SETUP, ASSERT, RELEASE, RESP with a down-counter of 8 bits.
REQ-016 The block SHALL drive req_ready = 1 only in IDLE; in IDLE an accepted request SHALL capture req_data into the value register and go to SETUP.
REQ-017 The block SHALL drive ff_rval from the value register at all times, changing only at the accept edge, so rval is stable one full cycle before ff_arst rises and for the whole time ff_arst is high.
REQ-018 The block SHALL drive ff_arst directly from a flop (no combinational logic after the register), high exactly in ASSERT.
REQ-019 Timing, with the accept edge as E0, SHALL be: SETUP during E0..E1; ff_arst high from E1 to E(1+HOLD); RELEASE from E(1+HOLD) to E(1+HOLD+SETTLE); rsp_valid rises at E(1+HOLD+SETTLE).
REQ-020 At the edge leaving RELEASE the block SHALL register rsp_err = (ff_q != value register).
REQ-021 In RESP the block SHALL hold rsp_valid = 1 and keep rsp_err stable until rsp_valid && rsp_ready; at that edge it SHALL return to IDLE, with rsp_valid low and req_ready high in the following cycle.
REQ-022 The block SHALL NOT accept a request in the same cycle as the response handshake; the minimum request-to-request spacing SHALL be HOLD+SETTLE+3 cycles.
REQ-023 The block SHALL ignore req_valid and req_data in every state except IDLE.
REQ-024 The block SHALL ignore ff_q in every cycle except the edge given in REQ-020.
REQ-025 With rsp_ready tied high, rsp_valid SHALL be a single-cycle pulse.
REQ-026 HOLD or SETTLE outside 1..255 SHALL be an elaboration error.

Reset
REQ-027 While arst = 1 the block SHALL hold state IDLE, counter 0, ff_arst 0, ff_rval 0, rsp_valid 0, rsp_err 0, and req_ready SHALL be 1 from the first clock edge after arst falls.
REQ-028 If arst is asserted during any phase, ff_arst SHALL drop to 0 asynchronously; the interrupted load SHALL produce no response, and the bank contents are left undefined.

Verification
REQ-029 Basic load (WIDTH=8, HOLD=2, SETTLE=1, bank of async-load flops connected, rsp_ready=1): accept 0xA5 at E0 -> ff_rval=0xA5 from E0; ff_arst high E1..E3; rsp_valid pulse at E4 with rsp_err=0; ff_q=0xA5.
REQ-030 Mismatch: bank bit 3 stuck at 0, load 0xFF -> rsp_err=1 at E4; load 0xF7 -> rsp_err=0.
REQ-031 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rsp_err stable; req_ready=0 throughout; a req_valid held high with 0x3C is accepted only in the cycle after the rsp handshake.
REQ-032 Mid-operation reset: arst pulsed while ff_arst=1 -> ff_arst=0 immediately with no clock; no rsp_valid; req_ready=1 after the first clock edge following reset release; the next load of 0x5A completes normally.
REQ-033 Parameter sweep: HOLD=1, SETTLE=1 and HOLD=255, SETTLE=255 -> ff_arst high exactly HOLD cycles; rsp_valid exactly HOLD+SETTLE+1 cycles after accept; back-to-back requests spaced HOLD+SETTLE+3 cycles.
